dma_if_pcie_rd_tag_arb: RTL and testbench
=========================================

# dma_if_pcie_rd_tag_arb

Multi-channel PCIe read-request tag arbiter for the DMA read path. It sits between several DMA read engines and the shared RQ TLP generator. It grants one PCIe tag per read TLP using round-robin arbitration, and it gates each grant on tag availability, extended-tag mode, TX in-flight limit (RQ sequence-number feedback) and non-posted header credits. It also keeps a tag-to-(channel, op tag) table that the RC completion path uses for lookup and release.

## Interface
- CHANNEL_COUNT, 4, number of requesting read engines (1..16)
- PCIE_TAG_COUNT, 256, PCIe tags managed (32..256, power of two)
- PCIE_TAG_WIDTH, $clog2(PCIE_TAG_COUNT), tag width
- OP_TAG_WIDTH, 8, per-channel operation tag width
- RQ_SEQ_NUM_WIDTH, 6, RQ sequence number width
- TX_LIMIT, 2**(RQ_SEQ_NUM_WIDTH-1), maximum granted-but-unreported TLPs
- TX_FC_ENABLE, 1, gate grants on pcie_tx_fc_nph_av
- CL_CH = $clog2(CHANNEL_COUNT) (min 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_req_valid  in  CHANNEL_COUNT  per-channel tag request
- s_req_op_tag  in  CHANNEL_COUNT*OP_TAG_WIDTH  per-channel op tag
- s_req_ready  out  CHANNEL_COUNT  one-hot accept
- m_grant_valid  out  1  grant available
- m_grant_ready  in  1  TLP generator accepts grant
- m_grant_channel  out  CL_CH  granted channel
- m_grant_op_tag  out  OP_TAG_WIDTH  granted op tag
- m_grant_pcie_tag  out  PCIE_TAG_WIDTH  allocated PCIe tag
- s_axis_rq_seq_num_0 / s_axis_rq_seq_num_valid_0  in  RQ_SEQ_NUM_WIDTH / 1  TLP sent, port 0
- s_axis_rq_seq_num_1 / s_axis_rq_seq_num_valid_1  in  RQ_SEQ_NUM_WIDTH / 1  TLP sent, port 1
- pcie_tx_fc_nph_av  in  8  available NP header credits
- s_release_tag / s_release_valid  in  PCIE_TAG_WIDTH / 1  final completion, free tag
- s_lookup_tag / s_lookup_valid  in  PCIE_TAG_WIDTH / 1  completion tag lookup
- m_lookup_channel / m_lookup_op_tag / m_lookup_valid  out  CL_CH / OP_TAG_WIDTH / 1  lookup result
- enable  in  1  allow new grants
- ext_tag_enable  in  1  0: allocate tags 0..31 only
- status_tags_in_use  out  PCIE_TAG_WIDTH+1  allocated tag count
- status_error_uncor  out  1  one-cycle pulse on release of a free tag

## Operation
- State: an in-use bitmap, a tag table {channel, op_tag}, a round-robin pointer, tx_cnt (granted TLPs minus reported sequence numbers), and a registered grant slot.
- Grant is possible when all of the following hold:
  - enable=1
  - the grant slot is empty or is being consumed this cycle (m_grant_valid & m_grant_ready)
  - a free tag exists in the allowed range
  - tx_cnt < TX_LIMIT
  - if TX_FC_ENABLE, pcie_tx_fc_nph_av > tx_cnt
- Channel selection: round robin. The first requesting channel at or after rr_ptr wins. rr_ptr then becomes winner+1 mod CHANNEL_COUNT.
- Tag selection: the lowest free tag. When ext_tag_enable=0, only tags 0..31 are searched.
- On grant:
  - s_req_ready[winner]=1 in that cycle (combinational)
  - bitmap bit is set and the table entry is written
  - grant slot is loaded; tx_cnt increments and status_tags_in_use increments
- tx_cnt decreases by the count of seq_num_valid_0 plus seq_num_valid_1 (0, 1 or 2), combined with any grant increment in the same cycle. Sequence-number values are ignored. Underflow saturates at 0.
- Release:
  - clears the bitmap bit and decrements status_tags_in_use
  - releasing a tag that is already free pulses status_error_uncor; the bitmap and count are then unchanged
- Release of tag T in the same cycle as an allocation: the allocation uses the pre-release bitmap, so T becomes allocatable the next cycle. The counter nets +1-1=0.
- Lookup: a registered read of the table. Lookup of a free tag returns stale data with m_lookup_valid=1; the caller is responsible for it.
- enable deasserted: no new grants. An occupied grant slot is held until consumed. Releases and lookups continue.

## Timing
- Request-to-grant: m_grant_valid rises 1 cycle after the s_req_ready pulse.
- Back-to-back: one grant per cycle while m_grant_ready=1.
- Grant outputs hold stable while m_grant_valid=1 and m_grant_ready=0.
- Lookup latency: 1 cycle.
- The error pulse is registered and appears 1 cycle after the release.
- Reset (async assert, sync deassert externally) clears:
  - bitmap, tx_cnt, rr_ptr, grant slot
  - all outputs are 0; s_req_ready is 0
  - table contents are don't-care
- Reset mid-operation discards outstanding grants and tags.

## Structure
- Shared package dma_pcie_pkg holds:
  - the tag-table entry typedef {channel, op_tag}
  - the constants TAG_COUNT_BASE=32 and RQ_SEQ_NUM_WIDTH defaults
- Sub-module: dma_pcie_prio_enc, a lowest-set-bit priority encoder with an allowed-range mask. It is used for free-tag search and reused, on a rotated mask, for round robin.

## Test plan
- Single channel, ext_tag_enable=0, m_grant_ready=1, 40 requests, no releases → tags 0..31 granted in order, then s_req_ready stays 0; status_tags_in_use=32.
- Four channels requesting continuously → grant channel order 0,1,2,3,0,…; op tags match each channel's input.
- pcie_tx_fc_nph_av=3, no seq_num feedback → exactly 3 grants. Then one seq_num_valid_0 and seq_num_valid_1 pulse in the same cycle → 2 more grants.
- All 256 tags in use, release tag 0x5A alongside a pending request → the next grant (one cycle later) carries tag 0x5A.
- Release tag 0x10 twice → second release pulses status_error_uncor one cycle later; count decrements once.
- m_grant_ready=0 for 5 cycles with requests pending → outputs stable, no further s_req_ready. Assert rst_n=0 mid-stream → all outputs 0 immediately; after release, allocation restarts at tag 0.

Source files
------------

// File: rtl/dma_pcie_pkg.sv
// Shared types and constants for the DMA PCIe read-request path.
// Tag-table entries are sized for the widest supported configuration.
package dma_pcie_pkg;

  localparam int TAG_COUNT_BASE       = 32;
  localparam int RQ_SEQ_NUM_WIDTH_DEF = 6;
  localparam int OP_TAG_WIDTH_DEF     = 8;
  localparam int CH_WIDTH_MAX         = 4;
  localparam int OP_TAG_WIDTH_MAX     = 16;

  typedef struct packed {
    logic [CH_WIDTH_MAX-1:0]     channel;
    logic [OP_TAG_WIDTH_MAX-1:0] op_tag;
  } tag_entry_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_pcie_prio_enc.sv
// Lowest-set-bit priority encoder over (req & mask).
// Used for free-tag search and, on a rotated request vector, for round robin.
module dma_pcie_prio_enc
  import dma_pcie_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] mask,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [WIDTH-1:0] masked;

  always_comb begin
    masked = req & mask;
    valid  = |masked;
    index  = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (masked[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/dma_if_pcie_rd_tag_arb.sv
// PCIe read-request tag arbiter: round-robin channel grant, lowest-free-tag
// allocation, TX in-flight / NP-credit gating, and tag -> {channel, op tag} table.
module dma_if_pcie_rd_tag_arb
  import dma_pcie_pkg::*;
#(
  parameter int CHANNEL_COUNT    = 4,
  parameter int PCIE_TAG_COUNT   = 256,
  parameter int PCIE_TAG_WIDTH   = $clog2(PCIE_TAG_COUNT),
  parameter int OP_TAG_WIDTH     = OP_TAG_WIDTH_DEF,
  parameter int RQ_SEQ_NUM_WIDTH = RQ_SEQ_NUM_WIDTH_DEF,
  parameter int TX_LIMIT         = 2**(RQ_SEQ_NUM_WIDTH-1),
  parameter int TX_FC_ENABLE     = 1,
  parameter int CL_CH            = clog2_min1(CHANNEL_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,

  input  logic [CHANNEL_COUNT-1:0]              s_req_valid,
  input  logic [CHANNEL_COUNT*OP_TAG_WIDTH-1:0] s_req_op_tag,
  output logic [CHANNEL_COUNT-1:0]              s_req_ready,

  output logic                                  m_grant_valid,
  input  logic                                  m_grant_ready,
  output logic [CL_CH-1:0]                      m_grant_channel,
  output logic [OP_TAG_WIDTH-1:0]               m_grant_op_tag,
  output logic [PCIE_TAG_WIDTH-1:0]             m_grant_pcie_tag,

  input  logic [RQ_SEQ_NUM_WIDTH-1:0]           s_axis_rq_seq_num_0,
  input  logic                                  s_axis_rq_seq_num_valid_0,
  input  logic [RQ_SEQ_NUM_WIDTH-1:0]           s_axis_rq_seq_num_1,
  input  logic                                  s_axis_rq_seq_num_valid_1,

  input  logic [7:0]                            pcie_tx_fc_nph_av,

  input  logic [PCIE_TAG_WIDTH-1:0]             s_release_tag,
  input  logic                                  s_release_valid,

  input  logic [PCIE_TAG_WIDTH-1:0]             s_lookup_tag,
  input  logic                                  s_lookup_valid,
  output logic [CL_CH-1:0]                      m_lookup_channel,
  output logic [OP_TAG_WIDTH-1:0]               m_lookup_op_tag,
  output logic                                  m_lookup_valid,

  input  logic                                  enable,
  input  logic                                  ext_tag_enable,

  output logic [PCIE_TAG_WIDTH:0]               status_tags_in_use,
  output logic                                  status_error_uncor
);

  localparam int TX_CNT_W = $clog2(TX_LIMIT + 2);

  logic [PCIE_TAG_COUNT-1:0]   in_use;
  logic [PCIE_TAG_COUNT-1:0]   in_use_nxt;
  logic [PCIE_TAG_COUNT-1:0]   tag_mask;
  logic [CL_CH-1:0]            rr_ptr;
  logic [TX_CNT_W-1:0]         tx_cnt;
  logic [TX_CNT_W-1:0]         tx_cnt_nxt;
  tag_entry_t                  tag_table [PCIE_TAG_COUNT];
  tag_entry_t                  lookup_q;

  logic                        tag_free;
  logic [PCIE_TAG_WIDTH-1:0]   free_tag;
  logic [2*CHANNEL_COUNT-1:0]  req_dbl;
  logic [CHANNEL_COUNT-1:0]    req_rot;
  logic                        req_any;
  logic [CL_CH-1:0]            rr_off;
  logic [CL_CH:0]              win_sum;
  logic [CL_CH-1:0]            winner;
  logic [CL_CH-1:0]            rr_nxt;
  logic [OP_TAG_WIDTH-1:0]     win_op_tag;
  logic                        tx_ok;
  logic                        slot_free;
  logic                        grant_en;
  logic                        rel_hit;
  logic                        rel_err;
  logic [TX_CNT_W:0]           tx_inc;
  logic [1:0]                  tx_dec;
  logic                        unused_bits;

  // Without extended tags only the base 32 tags are eligible.
  always_comb begin
    tag_mask = '0;
    tag_mask[TAG_COUNT_BASE-1:0] = '1;
    if (ext_tag_enable) tag_mask = '1;
  end

  dma_pcie_prio_enc #(
    .WIDTH (PCIE_TAG_COUNT),
    .IDX_W (PCIE_TAG_WIDTH)
  ) u_tag_enc (
    .req   (~in_use),
    .mask  (tag_mask),
    .valid (tag_free),
    .index (free_tag)
  );

  // Rotate requests so bit 0 is the channel at rr_ptr.
  assign req_dbl = {s_req_valid, s_req_valid} >> rr_ptr;
  assign req_rot = req_dbl[CHANNEL_COUNT-1:0];

  dma_pcie_prio_enc #(
    .WIDTH (CHANNEL_COUNT),
    .IDX_W (CL_CH)
  ) u_rr_enc (
    .req   (req_rot),
    .mask  ({CHANNEL_COUNT{1'b1}}),
    .valid (req_any),
    .index (rr_off)
  );

  always_comb begin
    win_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
    if (win_sum >= (CL_CH+1)'(CHANNEL_COUNT)) begin
      winner = CL_CH'(win_sum - (CL_CH+1)'(CHANNEL_COUNT));
    end else begin
      winner = CL_CH'(win_sum);
    end
    if (winner == CL_CH'(CHANNEL_COUNT - 1)) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = winner + 1'b1;
    end
  end

  assign win_op_tag = s_req_op_tag[winner*OP_TAG_WIDTH +: OP_TAG_WIDTH];

  assign tx_ok = (32'(tx_cnt) < 32'(TX_LIMIT)) &&
                 ((TX_FC_ENABLE == 0) || (32'(pcie_tx_fc_nph_av) > 32'(tx_cnt)));

  assign slot_free = !m_grant_valid || m_grant_ready;

  // rst_n is folded in so s_req_ready reads 0 the instant reset asserts.
  assign grant_en = rst_n && enable && slot_free && tag_free && req_any && tx_ok;

  always_comb begin
    s_req_ready = '0;
    if (grant_en) s_req_ready = CHANNEL_COUNT'(1) << winner;
  end

  assign rel_hit = s_release_valid &&  in_use[s_release_tag];
  assign rel_err = s_release_valid && !in_use[s_release_tag];

  // Allocation searches the pre-release bitmap; a released tag is reusable next cycle.
  always_comb begin
    in_use_nxt = in_use;
    if (rel_hit)  in_use_nxt[s_release_tag] = 1'b0;
    if (grant_en) in_use_nxt[free_tag]      = 1'b1;
  end

  always_comb begin
    tx_inc = {1'b0, tx_cnt} + (TX_CNT_W+1)'(grant_en);
    tx_dec = 2'(s_axis_rq_seq_num_valid_0) + 2'(s_axis_rq_seq_num_valid_1);
    if (tx_inc > (TX_CNT_W+1)'(tx_dec)) begin
      tx_cnt_nxt = TX_CNT_W'(tx_inc - (TX_CNT_W+1)'(tx_dec));
    end else begin
      tx_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_use             <= '0;
      tx_cnt             <= '0;
      rr_ptr             <= '0;
      m_grant_valid      <= 1'b0;
      m_grant_channel    <= '0;
      m_grant_op_tag     <= '0;
      m_grant_pcie_tag   <= '0;
      status_tags_in_use <= '0;
      status_error_uncor <= 1'b0;
      m_lookup_valid     <= 1'b0;
      lookup_q           <= '0;
    end else begin
      in_use             <= in_use_nxt;
      tx_cnt             <= tx_cnt_nxt;
      status_error_uncor <= rel_err;
      status_tags_in_use <= status_tags_in_use
                            + (PCIE_TAG_WIDTH+1)'(grant_en)
                            - (PCIE_TAG_WIDTH+1)'(rel_hit);
      if (grant_en) begin
        rr_ptr           <= rr_nxt;
        m_grant_valid    <= 1'b1;
        m_grant_channel  <= winner;
        m_grant_op_tag   <= win_op_tag;
        m_grant_pcie_tag <= free_tag;
      end else if (m_grant_ready) begin
        m_grant_valid    <= 1'b0;
      end
      m_lookup_valid <= s_lookup_valid;
      if (s_lookup_valid) lookup_q <= tag_table[s_lookup_tag];
    end
  end

  // Table contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      tag_table[free_tag] <= '{channel: CH_WIDTH_MAX'(winner),
                               op_tag:  OP_TAG_WIDTH_MAX'(win_op_tag)};
    end
  end

  assign m_lookup_channel = lookup_q.channel[CL_CH-1:0];
  assign m_lookup_op_tag  = lookup_q.op_tag[OP_TAG_WIDTH-1:0];

  // Sequence-number values carry no information here; only the valids count.
  assign unused_bits = ^{s_axis_rq_seq_num_0, s_axis_rq_seq_num_1, lookup_q};

endmodule

// File: tb/tb_dma_if_pcie_rd_tag_arb.sv
// Self-checking bench for dma_if_pcie_rd_tag_arb: expected grants are queued
// as stimulus is driven and compared when the grant handshake completes.
module tb_dma_if_pcie_rd_tag_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  s_req_valid;
  logic [31:0] s_req_op_tag;
  logic [3:0]  s_req_ready;
  logic        m_grant_valid;
  logic        m_grant_ready;
  logic [1:0]  m_grant_channel;
  logic [7:0]  m_grant_op_tag;
  logic [7:0]  m_grant_pcie_tag;
  logic [5:0]  seq_num_0;
  logic        seq_valid_0;
  logic [5:0]  seq_num_1;
  logic        seq_valid_1;
  logic [7:0]  fc_nph_av;
  logic [7:0]  s_release_tag;
  logic        s_release_valid;
  logic [7:0]  s_lookup_tag;
  logic        s_lookup_valid;
  logic [1:0]  m_lookup_channel;
  logic [7:0]  m_lookup_op_tag;
  logic        m_lookup_valid;
  logic        enable;
  logic        ext_tag_enable;
  logic [8:0]  status_tags_in_use;
  logic        status_error_uncor;

  dma_if_pcie_rd_tag_arb dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .s_req_valid               (s_req_valid),
    .s_req_op_tag              (s_req_op_tag),
    .s_req_ready               (s_req_ready),
    .m_grant_valid             (m_grant_valid),
    .m_grant_ready             (m_grant_ready),
    .m_grant_channel           (m_grant_channel),
    .m_grant_op_tag            (m_grant_op_tag),
    .m_grant_pcie_tag          (m_grant_pcie_tag),
    .s_axis_rq_seq_num_0       (seq_num_0),
    .s_axis_rq_seq_num_valid_0 (seq_valid_0),
    .s_axis_rq_seq_num_1       (seq_num_1),
    .s_axis_rq_seq_num_valid_1 (seq_valid_1),
    .pcie_tx_fc_nph_av         (fc_nph_av),
    .s_release_tag             (s_release_tag),
    .s_release_valid           (s_release_valid),
    .s_lookup_tag              (s_lookup_tag),
    .s_lookup_valid            (s_lookup_valid),
    .m_lookup_channel          (m_lookup_channel),
    .m_lookup_op_tag           (m_lookup_op_tag),
    .m_lookup_valid            (m_lookup_valid),
    .enable                    (enable),
    .ext_tag_enable            (ext_tag_enable),
    .status_tags_in_use        (status_tags_in_use),
    .status_error_uncor        (status_error_uncor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pk(input int ch, input int op, input int tag);
    return {12'd0, 4'(ch), 8'(op), 8'(tag)};
  endfunction

  // Scoreboard: every accepted grant must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && m_grant_valid && m_grant_ready) begin
      if (exp_q.size() == 0) begin
        chk("grant_extra", pk(m_grant_channel, m_grant_op_tag, m_grant_pcie_tag), 32'hFFFF_FFFF);
      end else begin
        chk("grant", pk(m_grant_channel, m_grant_op_tag, m_grant_pcie_tag), exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(output bit r);
    @(negedge clk);
    r = |s_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int cnt = 0;
    bit r;
    for (int i = 0; i < budget && cnt < n; i++) begin
      cyc(r);
      if (r) cnt++;
    end
    chk(tag, cnt, n);
  endtask

  task automatic count_for(input int cycles, output int cnt);
    bit r;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc(r);
      if (r) cnt++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || m_grant_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic lookup(input int tag, input int ch, input int op);
    s_lookup_tag   = 8'(tag);
    s_lookup_valid = 1'b1;
    @(posedge clk);
    #1 s_lookup_valid = 1'b0;
    chk("lookup_valid", m_lookup_valid, 1);
    chk("lookup_data", {20'd0, 4'(m_lookup_channel), m_lookup_op_tag}, {20'd0, 4'(ch), 8'(op)});
  endtask

  initial begin
    int cnt;
    bit r;
    rst_n = 1'b0;
    s_req_valid = '0;
    s_req_op_tag = '0;
    m_grant_ready = 1'b1;
    seq_num_0 = '0;
    seq_num_1 = '0;
    seq_valid_0 = 1'b1;
    seq_valid_1 = 1'b0;
    fc_nph_av = 8'hFF;
    s_release_tag = '0;
    s_release_valid = 1'b0;
    s_lookup_tag = '0;
    s_lookup_valid = 1'b0;
    enable = 1'b1;
    ext_tag_enable = 1'b0;
    do_reset();

    // Reset state
    chk("rst_grant_valid", m_grant_valid, 0);
    chk("rst_req_ready", s_req_ready, 0);
    chk("rst_in_use", status_tags_in_use, 0);
    chk("rst_err", status_error_uncor, 0);
    chk("rst_lookup_valid", m_lookup_valid, 0);

    // Base tags only: 32 grants in tag order, then no more
    for (int i = 0; i < 32; i++) exp_q.push_back(pk(0, 8'h11, i));
    s_req_op_tag = 32'h0000_0011;
    s_req_valid = 4'b0001;
    count_for(40, cnt);
    s_req_valid = '0;
    chk("base_tag_grants", cnt, 32);
    drain();
    chk("base_tag_in_use", status_tags_in_use, 32);

    // Four channels, round robin, enable gating first
    do_reset();
    ext_tag_enable = 1'b1;
    s_req_op_tag = 32'hA3A2_A1A0;
    for (int i = 0; i < 12; i++) exp_q.push_back(pk(i % 4, 8'hA0 + i % 4, i));
    enable = 1'b0;
    s_req_valid = 4'hF;
    cyc(r);
    chk("enable_off_ready", r, 0);
    enable = 1'b1;
    run_until(12, 40, "rr_grants");
    s_req_valid = '0;
    drain();
    lookup(5, 1, 8'hA1);
    lookup(10, 2, 8'hA2);

    // NP credit gating and sequence-number feedback
    seq_valid_0 = 1'b0;
    do_reset();
    fc_nph_av = 8'd3;
    s_req_op_tag = 32'h0000_0033;
    for (int i = 0; i < 5; i++) exp_q.push_back(pk(0, 8'h33, i));
    s_req_valid = 4'b0001;
    count_for(10, cnt);
    chk("fc_grants_first", cnt, 3);
    seq_valid_0 = 1'b1;
    seq_valid_1 = 1'b1;
    cyc(r);
    seq_valid_0 = 1'b0;
    seq_valid_1 = 1'b0;
    count_for(9, cnt);
    chk("fc_grants_second", cnt + int'(r), 2);
    s_req_valid = '0;
    drain();
    fc_nph_av = 8'hFF;
    seq_valid_0 = 1'b1;

    // Fill all 256 tags, then release 0x5A under a pending request
    do_reset();
    s_req_op_tag = 32'h0000_0044;
    for (int i = 0; i < 256; i++) exp_q.push_back(pk(0, 8'h44, i));
    s_req_valid = 4'b0001;
    run_until(256, 300, "fill_grants");
    count_for(3, cnt);
    chk("full_no_grant", cnt, 0);
    chk("full_in_use", status_tags_in_use, 256);
    exp_q.push_back(pk(0, 8'h44, 8'h5A));
    s_release_tag = 8'h5A;
    s_release_valid = 1'b1;
    cyc(r);
    chk("release_cycle_ready", r, 0);
    s_release_valid = 1'b0;
    cyc(r);
    chk("reuse_cycle_ready", r, 1);
    s_req_valid = '0;
    drain();
    chk("reuse_in_use", status_tags_in_use, 256);
    lookup(8'h5A, 0, 8'h44);

    // Double release of 0x10
    s_release_tag = 8'h10;
    s_release_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("err_first_release", status_error_uncor, 0);
    @(posedge clk);
    #1 s_release_valid = 1'b0;
    @(negedge clk);
    chk("err_second_release", status_error_uncor, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("err_pulse_end", status_error_uncor, 0);
    chk("double_release_in_use", status_tags_in_use, 255);
    @(posedge clk);
    #1;

    // Back-pressure: slot holds, no further accepts
    do_reset();
    m_grant_ready = 1'b0;
    s_req_op_tag = 32'hA3A2_A1A0;
    exp_q.push_back(pk(0, 8'hA0, 0));
    s_req_valid = 4'hF;
    cyc(r);
    chk("bp_first_ready", r, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(r);
      chk("bp_ready", r, 0);
      chk("bp_valid", m_grant_valid, 1);
      chk("bp_hold", pk(m_grant_channel, m_grant_op_tag, m_grant_pcie_tag), pk(0, 8'hA0, 0));
    end
    for (int i = 1; i < 4; i++) exp_q.push_back(pk(i, 8'hA0 + i, i));
    m_grant_ready = 1'b1;
    run_until(3, 10, "bp_resume");
    s_req_valid = '0;
    drain();

    // Reset mid-stream: the grant loaded just before reset is discarded
    exp_q.push_back(pk(0, 8'hA0, 4));
    s_req_valid = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant_valid", m_grant_valid, 0);
    chk("mid_rst_req_ready", s_req_ready, 0);
    chk("mid_rst_in_use", status_tags_in_use, 0);
    chk("mid_rst_tag", m_grant_pcie_tag, 0);
    s_req_valid = 4'b0001;
    exp_q.push_back(pk(0, 8'hA0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_until(1, 5, "post_rst_grant");
    s_req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
